// File: rtl/cr_fifo_rd_stage_if.sv
// Handshake bundle between a show-ahead FIFO, the read stage and its consumer.
// master: the read stage; slave: the FIFO/consumer environment.
interface cr_fifo_rd_stage_if #(
   parameter int N_DATA_BITS = 64
);
   logic [N_DATA_BITS-1:0] fifo_rdata;
   logic                   fifo_empty;
   logic                   fifo_ren;
   logic [N_DATA_BITS-1:0] out_data;
   logic                   out_valid;
   logic                   out_ready;

   modport master (
      input  fifo_rdata,
      input  fifo_empty,
      input  out_ready,
      output fifo_ren,
      output out_data,
      output out_valid
   );

   modport slave (
      output fifo_rdata,
      output fifo_empty,
      output out_ready,
      input  fifo_ren,
      input  out_data,
      input  out_valid
   );
endinterface

// File: rtl/cr_fifo_rd_stage.sv
// Show-ahead FIFO read stage: 2-entry registered skid buffer, fifo_ren never sees out_ready.
// Optional statistics counters are built when CR_FIFO_RD_STAGE_STATS_EN is defined.
module cr_fifo_rd_stage #(
   parameter int N_DATA_BITS = 64,
   parameter int N_CNT_BITS  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cr_fifo_rd_stage_if.master    io,
   input  logic                  clear_i,
   output logic [N_CNT_BITS-1:0] pop_cnt_o,
   output logic [N_CNT_BITS-1:0] stall_cnt_o
);

   logic [1:0]             occ_q, occ_d;
   logic [N_DATA_BITS-1:0] e0_q, e0_d;
   logic [N_DATA_BITS-1:0] e1_q, e1_d;
   logic                   push;
   logic                   pop;

   // Pop decision uses registered occupancy only, so the consumer's ready has no path into the FIFO.
   assign push         = rst_n & ~clear_i & ~io.fifo_empty & (occ_q < 2'd2);
   assign pop          = io.out_valid & io.out_ready & ~clear_i;
   assign io.fifo_ren  = push;
   assign io.out_valid = (occ_q != 2'd0);
   assign io.out_data  = e0_q;

   always_comb begin
      occ_d = occ_q;
      e0_d  = e0_q;
      e1_d  = e1_q;
      if (clear_i) begin
         occ_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ_q == 2'd0) e0_d = io.fifo_rdata;
               else               e1_d = io.fifo_rdata;
               occ_d = occ_q + 2'd1;
            end
            2'b01: begin
               // Draining the last entry leaves e0 untouched so out_data holds.
               if (occ_q == 2'd2) e0_d = e1_q;
               occ_d = occ_q - 2'd1;
            end
            2'b11: begin
               // Push implies occ<2 and pop implies occ>0, so occ==1: new word becomes head.
               e0_d = io.fifo_rdata;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= 2'd0;
         e0_q  <= '0;
         e1_q  <= '0;
      end else begin
         occ_q <= occ_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
      end
   end

`ifdef CR_FIFO_RD_STAGE_STATS_EN
   logic [N_CNT_BITS-1:0] pop_cnt_q, pop_cnt_d;
   logic [N_CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      pop_cnt_d   = pop_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (clear_i) begin
         pop_cnt_d   = '0;
         stall_cnt_d = '0;
      end else begin
         if (pop && (pop_cnt_q != '1))
            pop_cnt_d = pop_cnt_q + 1'b1;
         if (io.out_valid && !io.out_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         pop_cnt_q   <= pop_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign pop_cnt_o   = pop_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`else
   assign pop_cnt_o   = '0;
   assign stall_cnt_o = '0;
`endif

   a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= 2'd2);
   a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n) !(pop && (occ_q == 2'd0)));

endmodule

// File: tb/tb_cr_fifo_rd_stage.sv
// Directed bench for cr_fifo_rd_stage: queue-based reference model checked every cycle,
// plus hand-computed expectations per scenario. Honours CR_FIFO_RD_STAGE_STATS_EN.
module tb_cr_fifo_rd_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_i = 1'b0;
   logic [31:0] pop_cnt_o, stall_cnt_o;

   int errors = 0;
   int checks = 0;

   cr_fifo_rd_stage_if #(.N_DATA_BITS(64)) ifc ();

   cr_fifo_rd_stage #(.N_DATA_BITS(64), .N_CNT_BITS(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .io          (ifc.master),
      .clear_i     (clear_i),
      .pop_cnt_o   (pop_cnt_o),
      .stall_cnt_o (stall_cnt_o)
   );

   always #5 clk = ~clk;

   logic [63:0] src[$];   // words still inside the upstream FIFO
   logic [63:0] mq[$];    // model of the output buffer, head at index 0
   logic [63:0] got[$];   // words the consumer actually accepted
   logic [31:0] exp_pop = 0, exp_stall = 0;
   int ren_seen, ren_run, ren_run_max, xfer_run, xfer_run_max, vld_run, vld_run_max;
   logic last_valid;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clr_log();
      got.delete();
      ren_seen = 0; ren_run = 0; ren_run_max = 0;
      xfer_run = 0; xfer_run_max = 0; vld_run = 0; vld_run_max = 0;
   endtask

   // One clock cycle: drive inputs, compare at negedge, advance model to the next edge.
   task automatic cyc(input logic rdy, input logic clr);
      logic ren_m, pop_m, xfer;
      ifc.out_ready  = rdy;
      clear_i        = clr;
      ifc.fifo_empty = (src.size() == 0);
      ifc.fifo_rdata = (src.size() != 0) ? src[0] : 64'h0;
      @(negedge clk);
      ren_m = rst_n && !clr && (src.size() != 0) && (mq.size() < 2);
      chk("fifo_ren", {63'd0, ifc.fifo_ren}, {63'd0, ren_m});
      chk("out_valid", {63'd0, ifc.out_valid}, {63'd0, mq.size() != 0});
      if (mq.size() != 0) chk("out_data", ifc.out_data, mq[0]);
      chk("pop_cnt", {32'd0, pop_cnt_o}, {32'd0, exp_pop});
      chk("stall_cnt", {32'd0, stall_cnt_o}, {32'd0, exp_stall});

      last_valid = ifc.out_valid;
      xfer = ifc.out_valid && rdy && !clr;
      if (xfer) got.push_back(ifc.out_data);
      if (ifc.fifo_ren) begin ren_seen++; ren_run++; end else ren_run = 0;
      if (xfer) xfer_run++; else xfer_run = 0;
      if (ifc.out_valid) vld_run++; else vld_run = 0;
      if (ren_run > ren_run_max) ren_run_max = ren_run;
      if (xfer_run > xfer_run_max) xfer_run_max = xfer_run;
      if (vld_run > vld_run_max) vld_run_max = vld_run;

      pop_m = rst_n && !clr && (mq.size() != 0) && rdy;
`ifdef CR_FIFO_RD_STAGE_STATS_EN
      if (!rst_n || clr) begin
         exp_pop = 0; exp_stall = 0;
      end else begin
         if (pop_m && exp_pop != 32'hFFFF_FFFF) exp_pop++;
         if (mq.size() != 0 && !rdy && exp_stall != 32'hFFFF_FFFF) exp_stall++;
      end
`endif
      if (!rst_n || clr) mq.delete();
      else begin
         if (pop_m) void'(mq.pop_front());
         if (ren_m) mq.push_back(src.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((src.size() != 0 || mq.size() != 0) && n < 40) begin
         cyc(1'b1, 1'b0);
         n++;
      end
      chk("drain_done", {63'd0, (src.size() == 0 && mq.size() == 0)}, 64'd1);
   endtask

   initial begin
      ifc.out_ready = 1'b0; ifc.fifo_empty = 1'b1; ifc.fifo_rdata = '0;

      // Reset held with a non-empty FIFO
      clr_log();
      src.push_back(64'h11);
      #1;
      chk("rst_ren", {63'd0, ifc.fifo_ren}, 64'd0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("rst_valid", {63'd0, ifc.out_valid}, 64'd0);
      chk("rst_data", ifc.out_data, 64'd0);
      rst_n = 1'b1;
      cyc(1'b1, 1'b0);
      chk("rel_ren_first", ren_seen, 64'd1);
      drain();

      // Single word
      clr_log();
      src.push_back(64'hA5);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("single_valid", {63'd0, last_valid}, 64'd1);
      cyc(1'b1, 1'b0);
      chk("single_after", {63'd0, last_valid}, 64'd0);
      chk("single_cnt", got.size(), 64'd1);
      if (got.size() == 1) chk("single_data", got[0], 64'hA5);
      chk("single_ren", ren_seen, 64'd1);

      // Streaming 0..15
      clr_log();
      for (int i = 0; i < 16; i++) src.push_back(64'(i));
      repeat (20) cyc(1'b1, 1'b0);
      chk("stream_cnt", got.size(), 64'd16);
      for (int i = 0; i < 16 && i < got.size(); i++) chk("stream_data", got[i], 64'(i));
      chk("stream_ren_run", ren_run_max, 64'd16);
      chk("stream_vld_run", vld_run_max, 64'd16);

      // Backpressure with 5 words
      clr_log();
      for (int i = 0; i < 5; i++) src.push_back(64'h40 + 64'(i));
      repeat (6) cyc(1'b0, 1'b0);
      chk("bp_ren", ren_seen, 64'd2);
      chk("bp_hold", ifc.out_data, 64'h40);
      repeat (8) cyc(1'b1, 1'b0);
      chk("bp_cnt", got.size(), 64'd5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_data", got[i], 64'h40 + 64'(i));
      chk("bp_b2b", xfer_run_max, 64'd5);

      // Clear with occ=2 and 3 words left upstream
      clr_log();
      for (int i = 0; i < 5; i++) src.push_back(64'h50 + 64'(i));
      repeat (3) cyc(1'b0, 1'b0);
      ren_seen = 0;
      cyc(1'b1, 1'b1);
      chk("clr_ren", ren_seen, 64'd0);
      cyc(1'b1, 1'b0);
      chk("clr_valid_next", {63'd0, last_valid}, 64'd0);
      drain();
      chk("clr_cnt", got.size(), 64'd3);
      for (int i = 0; i < 3 && i < got.size(); i++) chk("clr_data", got[i], 64'h52 + 64'(i));

      // Asynchronous reset mid-stream
      clr_log();
      for (int i = 0; i < 3; i++) src.push_back(64'h70 + 64'(i));
      repeat (2) cyc(1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", {63'd0, ifc.out_valid}, 64'd0);
      chk("mrst_data", ifc.out_data, 64'd0);
      chk("mrst_ren", {63'd0, ifc.fifo_ren}, 64'd0);
      chk("mrst_pop_cnt", {32'd0, pop_cnt_o}, 64'd0);
      mq.delete(); exp_pop = 0; exp_stall = 0;
      cyc(1'b0, 1'b0);
      rst_n = 1'b1;
      drain();
      chk("mrst_cnt", got.size(), 64'd1);
      if (got.size() == 1) chk("mrst_data_out", got[0], 64'h72);

      // Statistics: 3 stalls then 4 transfers
      clr_log();
      cyc(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) src.push_back(64'h90 + 64'(i));
      repeat (4) cyc(1'b0, 1'b0);
      drain();
      cyc(1'b1, 1'b0);
`ifdef CR_FIFO_RD_STAGE_STATS_EN
      chk("stats_pop", {32'd0, pop_cnt_o}, 64'd4);
      chk("stats_stall", {32'd0, stall_cnt_o}, 64'd3);
`else
      chk("stats_pop", {32'd0, pop_cnt_o}, 64'd0);
      chk("stats_stall", {32'd0, stall_cnt_o}, 64'd0);
`endif
      chk("stats_xfers", got.size(), 64'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
